// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative radix-2 multiply/divide unit with HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  input  logic                  mthi_i,
  input  logic                  mtlo_i,
  input  logic [DATA_WIDTH-1:0] move_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  localparam int                   c_W        = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] c_CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2*c_W-1:0]     r_acc;
  logic [c_W-1:0]       r_b;
  logic                 r_is_div;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic                 r_dbz_pend;
  logic                 r_done;
  logic                 r_dbz;
  logic [c_W-1:0]       r_hi;
  logic [c_W-1:0]       r_lo;

  // Launch decode: magnitudes and sign flags for the signed ops
  logic           w_accept;
  logic           w_signed;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [c_W-1:0] w_a_mag;
  logic [c_W-1:0] w_b_mag;
  logic           w_dbz;

  assign w_accept = start_i & ~flush_i;
  assign w_signed = ~op_i[0];
  assign w_a_neg  = w_signed & a_i[c_W-1];
  assign w_b_neg  = w_signed & b_i[c_W-1];
  assign w_a_mag  = w_a_neg ? -a_i : a_i;
  assign w_b_mag  = w_b_neg ? -b_i : b_i;
  assign w_dbz    = op_i[1] & (b_i == '0);

  // Multiply step: r_acc holds {partial product high half, remaining multiplier bits}
  logic [c_W:0]     w_mul_sum;
  logic [2*c_W-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*c_W-1:c_W]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[c_W-1:1]};

  // Divide step: r_acc holds {partial remainder, dividend bits shifting into quotient}
  logic [c_W:0]     w_rem_sh;
  logic             w_ge;
  logic [c_W-1:0]   w_rem_sub;
  logic [2*c_W-1:0] w_div_next;

  assign w_rem_sh   = r_acc[2*c_W-1:c_W-1];
  assign w_ge       = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub  = w_rem_sh[c_W-1:0] - r_b;
  assign w_div_next = w_ge ? {w_rem_sub, r_acc[c_W-2:0], 1'b1}
                           : {w_rem_sh[c_W-1:0], r_acc[c_W-2:0], 1'b0};

  // Sign correction applied in FIX
  logic [2*c_W-1:0] w_mul_res;
  logic [c_W-1:0]   w_quot;
  logic [c_W-1:0]   w_rem;
  logic [c_W-1:0]   w_fix_hi;
  logic [c_W-1:0]   w_fix_lo;

  assign w_mul_res = r_neg_res ? -r_acc : r_acc;
  assign w_quot    = r_acc[c_W-1:0];
  assign w_rem     = r_acc[2*c_W-1:c_W];
  assign w_fix_hi  = r_is_div ? (r_neg_rem ? -w_rem : w_rem) : w_mul_res[2*c_W-1:c_W];
  assign w_fix_lo  = r_is_div ? (r_neg_res ? -w_quot : w_quot) : w_mul_res[c_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_dbz ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_CNT_ONE) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_b        <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc      <= {{c_W{1'b0}}, w_a_mag};
            r_b        <= w_b_mag;
            r_cnt      <= c_CNT_LOAD;
            r_is_div   <= op_i[1];
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= op_i[1] & w_a_neg;
            r_dbz_pend <= w_dbz;
          end else if (!start_i) begin
            if (mthi_i) r_hi <= move_data_i;
            if (mtlo_i) r_lo <= move_data_i;
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - c_CNT_ONE;
        end
        S_FIX: begin
          r_cnt <= '0;
          if (!flush_i) begin
            r_done <= 1'b1;
            r_dbz  <= r_dbz_pend;
            if (!r_dbz_pend) begin
              r_hi <= w_fix_hi;
              r_lo <= w_fix_lo;
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = r_done;
  assign div_by_zero_o = r_dbz;
  assign hi_o          = r_hi;
  assign lo_o          = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         flush_i = 1'b0;
  logic         mthi_i = 1'b0;
  logic         mtlo_i = 1'b0;
  logic [W-1:0] move_data_i = '0;
  logic         busy_o;
  logic         done_o;
  logic         div_by_zero_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .op_i         (op_i),
    .a_i          (a_i),
    .b_i          (b_i),
    .flush_i      (flush_i),
    .mthi_i       (mthi_i),
    .mtlo_i       (mtlo_i),
    .move_data_i  (move_data_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .div_by_zero_o(div_by_zero_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dbz);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    dbz = 1'b0;
    hi  = m_hi;
    lo  = m_lo;
    case (op)
      2'b00: begin
        p  = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b01: begin
        p  = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b10: begin
        if (b == '0) dbz = 1'b1;
        else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      default: begin
        if (b == '0) dbz = 1'b1;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endtask

  // Called at a negedge; returns at the negedge where done_o is observed
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit disturb);
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         ed;
    int           k;
    int           busy_cnt;
    bit           seen;
    model(op, a, b, eh, el, ed);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(negedge clk);
    start_i  = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
    busy_cnt = busy_o ? 1 : 0;
    seen     = 1'b0;
    k        = 0;
    while (!seen && k < 100) begin
      k++;
      @(negedge clk);
      if (done_o) seen = 1'b1;
      else begin
        if (busy_o) busy_cnt++;
        if (disturb && k == 3) begin
          start_i     = 1'b1;
          op_i        = ~op;
          mthi_i      = 1'b1;
          mtlo_i      = 1'b1;
          move_data_i = $urandom;
        end else if (disturb && k == 6) begin
          start_i = 1'b0;
          mthi_i  = 1'b0;
          mtlo_i  = 1'b0;
        end
      end
    end
    chk("done_seen", 64'(seen), 64'(1));
    chk("latency", 64'(k), ed ? 64'(1) : 64'(33));
    chk("busy_cycles", 64'(busy_cnt), ed ? 64'(1) : 64'(33));
    chk("busy_at_done", 64'(busy_o), 64'(0));
    chk("div_by_zero", 64'(div_by_zero_o), 64'(ed));
    chk("hi", 64'(hi_o), 64'(eh));
    chk("lo", 64'(lo_o), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  task automatic move(input bit wr_hi, input bit wr_lo, input logic [W-1:0] d);
    mthi_i      = wr_hi;
    mtlo_i      = wr_lo;
    move_data_i = d;
    @(negedge clk);
    mthi_i = 1'b0;
    mtlo_i = 1'b0;
    if (wr_hi) m_hi = d;
    if (wr_lo) m_lo = d;
    chk("move_hi", 64'(hi_o), 64'(m_hi));
    chk("move_lo", 64'(lo_o), 64'(m_lo));
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           dones;

    // Reset state
    #12;
    chk("rst_hi", 64'(hi_o), 64'(0));
    chk("rst_lo", 64'(lo_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_dbz", 64'(div_by_zero_o), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases from the test plan
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    chk("mult_hi_const", 64'(hi_o), 64'hFFFF_FFFF);
    chk("mult_lo_const", 64'(lo_o), 64'hFFFF_FFEB);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_hi_const", 64'(hi_o), 64'hFFFF_FFFE);
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    chk("divu_lo_const", 64'(lo_o), 64'h0000_000E);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    chk("div_lo_const", 64'(lo_o), 64'hFFFF_FFFD);
    chk("div_hi_const", 64'(hi_o), 64'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divmin_lo_const", 64'(lo_o), 64'h8000_0000);
    chk("divmin_hi_const", 64'(hi_o), 64'h0000_0000);

    // Moves, then divide by zero leaves HI/LO intact
    move(1'b1, 1'b0, 32'h0000_ABCD);
    move(1'b0, 1'b1, 32'h1234_5678);
    run_op(2'b10, 32'd5, 32'd0, 1'b0);
    chk("dbz_hi_kept", 64'(hi_o), 64'h0000_ABCD);

    // start/mthi/mtlo while busy are ignored
    run_op(2'b00, 32'h0001_2345, 32'hFFFF_F000, 1'b1);

    // Flush mid-multiply
    start_i = 1'b1;
    op_i    = 2'b00;
    a_i     = 32'h1357_9BDF;
    b_i     = 32'h0246_8ACE;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", 64'(busy_o), 64'(0));
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    chk("flush_no_done", 64'(dones), 64'(0));
    chk("flush_hi", 64'(hi_o), 64'(m_hi));
    chk("flush_lo", 64'(lo_o), 64'(m_lo));

    // start together with flush in IDLE
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 2'b01;
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    chk("start_flush_busy", 64'(busy_o), 64'(0));
    @(negedge clk);
    chk("start_flush_done", 64'(done_o), 64'(0));

    // Back-to-back: second start issued in the done cycle
    run_op(2'b01, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
    run_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if (i % 5 == 4)             rb = '0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else                        rb = W'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) rb = -rb;
      if (i % 4 == 0) move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(rop, ra, rb, 1'b0);
    end

    // Async reset mid-divide
    move(1'b1, 1'b1, 32'hDEAD_BEEF);
    start_i = 1'b1;
    op_i    = 2'b10;
    a_i     = 32'h0000_1234;
    b_i     = 32'h0000_0011;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_hi", 64'(hi_o), 64'(0));
    chk("arst_lo", 64'(lo_o), 64'(0));
    chk("arst_busy", 64'(busy_o), 64'(0));
    chk("arst_done", 64'(done_o), 64'(0));
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
